// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side handshake bundle for mem_arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ack, mem_rdata,
        output if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Requesters plus memory (environment) side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_ack, mem_rdata,
        input  if_valid, if_rdata, if_err, d_valid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection with a saturating data-streak counter that guarantees
// fetch a grant after MAX_D_STREAK consecutive data grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_arb,
    input  logic   i_if_req,
    input  logic   i_d_req,
    output owner_t o_winner
);
    localparam int unsigned    CW    = $clog2(MAX_D_STREAK + 1);
    localparam logic [CW-1:0]  C_MAX = CW'(MAX_D_STREAK);

    logic [CW-1:0] r_streak;
    logic          w_fetch_turn;

    assign w_fetch_turn = i_if_req && (r_streak == C_MAX);

    // Data wins unless fetch is waiting and the streak has reached its cap
    always_comb begin
        o_winner = OWN_IF;
        if (i_d_req && !w_fetch_turn) begin
            o_winner = OWN_D;
        end
    end

    // Streak counter: counts data grants taken while fetch is waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (i_arb) begin
            if (o_winner == OWN_IF || !i_if_req) begin
                r_streak <= '0;
            end else if (r_streak != C_MAX) begin
                r_streak <= r_streak + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction
// fetch and load/store, rejecting misaligned requests without a memory access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    owner_t            w_winner;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_rdata;

    logic              w_arb;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_sel_addr;

    logic              w_mem_req;
    logic              w_if_sel;
    logic              w_d_sel;

    assign w_arb = (r_state == IDLE) && (bus.if_req || bus.d_req);

    mem_arb_prio #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .i_arb    (w_arb),
        .i_if_req (bus.if_req),
        .i_d_req  (bus.d_req),
        .o_winner (w_winner)
    );

    assign w_sel_addr   = (w_winner == OWN_D) ? bus.d_addr : bus.if_addr;
    assign w_misaligned = is_misaligned(w_sel_addr[1:0]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: misaligned requests skip ACCESS entirely
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb) begin
                    w_state_nxt = w_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch at arbitration, read-data capture on ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_owner <= w_winner;
                        r_addr  <= w_sel_addr;
                        r_err   <= w_misaligned;
                        r_rdata <= '0;
                        if (w_winner == OWN_D) begin
                            r_we    <= bus.d_we;
                            r_wdata <= bus.d_wdata;
                            r_be    <= bus.d_be;
                        end else begin
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_be    <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        r_rdata <= r_we ? '0 : bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously
    always_comb begin
        w_mem_req = (r_state == ACCESS);
        w_if_sel  = (r_state == RESP) && (r_owner == OWN_IF);
        w_d_sel   = (r_state == RESP) && (r_owner == OWN_D);
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_req & r_we;
    assign bus.mem_addr  = w_mem_req ? r_addr  : '0;
    assign bus.mem_wdata = w_mem_req ? r_wdata : '0;
    assign bus.mem_be    = w_mem_req ? r_be    : '0;

    assign bus.if_valid  = w_if_sel;
    assign bus.if_err    = w_if_sel & r_err;
    assign bus.if_rdata  = w_if_sel ? r_rdata : '0;
    assign bus.d_valid   = w_d_sel;
    assign bus.d_err     = w_d_sel & r_err;
    assign bus.d_rdata   = w_d_sel ? r_rdata : '0;

endmodule
